// File: rtl/cpu_defs.sv
// Shared definitions for the memory port arbiter: FSM state encoding and
// requester IDs. Requester IDs equal the address/wdata mux select value, so a
// registered grant can drive sel directly.
package cpu_defs;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  localparam logic REQ_A = 1'b1;
  localparam logic REQ_B = 1'b0;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick. On a tie the requester that did not win last
// time gets the port; a lone requester always wins.
module rr_pick2
  import cpu_defs::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic gnt,
  output logic valid
);

  // Select the winner among the active requests.
  always_comb begin
    valid = req_a | req_b;
    gnt   = REQ_B;
    if (req_a && req_b) begin
      gnt = ~last;
    end else if (req_a) begin
      gnt = REQ_A;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between an instruction-side requester (A)
// and a data-side requester (B). The grant is held until the memory acks or
// the transfer times out.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | port free; arbitrate among pending requests
// ST_XFER | port owned by grant_q; waiting for mem_ack or the timeout
module mem_port_arbiter
  import cpu_defs::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic        we_a,
  input  logic        req_b,
  input  logic        we_b,
  output logic        sel,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ack_a,
  output logic        ack_b,
  output logic        err_a,
  output logic        err_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  output logic        busy
);

  // Count value on the last cycle a transfer may wait before it is dropped.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic pick_gnt;
  logic pick_valid;
  logic timeout_hit;
  logic xfer_done_ack;
  logic xfer_done_err;

  rr_pick2 u_pick (
    .req_a (req_a),
    .req_b (req_b),
    .last  (last_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // Both requesters see the raw memory read data; it is only meaningful in
  // the cycle their ack is high.
  assign rdata_a = mem_rdata;
  assign rdata_b = mem_rdata;

  // Timeout compare; a zero TIMEOUT disables it entirely.
  always_comb begin
    timeout_hit = 1'b0;
    if (TIMEOUT != 0) begin
      timeout_hit = (cnt_q == CNT_LAST);
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    sel           = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    busy          = 1'b0;
    xfer_done_ack = 1'b0;
    xfer_done_err = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_XFER;
          grant_d = pick_gnt;
          last_d  = pick_gnt;
          cnt_d   = '0;
        end
      end
      ST_XFER: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        sel     = (grant_q == REQ_A);
        mem_we  = (grant_q == REQ_A) ? we_a : we_b;
        if (mem_ack) begin
          // Ack has priority over a coincident timeout.
          xfer_done_ack = 1'b1;
          state_d       = ST_IDLE;
        end else if (timeout_hit) begin
          xfer_done_err = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Completion strobes routed to the owner. A transfer cut short by reset
  // reports neither ack nor err, so the strobes are masked while reset is low.
  always_comb begin
    ack_a = reset & xfer_done_ack & (grant_q == REQ_A);
    ack_b = reset & xfer_done_ack & (grant_q == REQ_B);
    err_a = reset & xfer_done_err & (grant_q == REQ_A);
    err_b = reset & xfer_done_err & (grant_q == REQ_B);
  end

  // State registers with synchronous active-low reset; last starts at B so
  // the first tie after reset goes to A.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      grant_q <= REQ_B;
      last_q  <= REQ_B;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized run, every cycle compared against a transfer-level model.
module tb_mem_port_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, we_a, req_b, we_b;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        sel, mem_req, mem_we, busy;
  logic        ack_a, ack_b, err_a, err_b;
  logic [31:0] rdata_a, rdata_b;

  int checks = 0;
  int errors = 0;

  // Transfer-level model: is a transfer open, who owns it, how many cycles
  // it has been waiting, and who won the previous arbitration.
  bit m_open;
  bit m_owner_a;
  bit m_prev_a;
  int m_waited;

  bit grant_log[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .we_a      (we_a),
    .req_b     (req_b),
    .we_b      (we_b),
    .sel       (sel),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ack_a     (ack_a),
    .ack_b     (ack_b),
    .err_a     (err_a),
    .err_b     (err_b),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs applied: compare the cycle's
  // outputs with the model, then advance the model across the rising edge.
  task automatic tick();
    bit fin_ack, fin_err, live;
    #1;
    live    = (reset === 1'b1);
    fin_ack = m_open && mem_ack && live;
    fin_err = m_open && !mem_ack && (TMO != 0) && (m_waited + 1 == TMO) && live;
    chk("busy",    {31'd0, busy},    {31'd0, m_open});
    chk("mem_req", {31'd0, mem_req}, {31'd0, m_open});
    chk("sel",     {31'd0, sel},     {31'd0, m_open && m_owner_a});
    chk("mem_we",  {31'd0, mem_we},  {31'd0, m_open && (m_owner_a ? we_a : we_b)});
    chk("ack_a",   {31'd0, ack_a},   {31'd0, fin_ack && m_owner_a});
    chk("ack_b",   {31'd0, ack_b},   {31'd0, fin_ack && !m_owner_a});
    chk("err_a",   {31'd0, err_a},   {31'd0, fin_err && m_owner_a});
    chk("err_b",   {31'd0, err_b},   {31'd0, fin_err && !m_owner_a});
    chk("rdata_a", rdata_a, mem_rdata);
    chk("rdata_b", rdata_b, mem_rdata);
    @(posedge clk);
    if (!live) begin
      m_open   = 1'b0;
      m_prev_a = 1'b0;
      m_waited = 0;
    end else if (m_open) begin
      if (mem_ack || ((TMO != 0) && (m_waited + 1 == TMO))) m_open = 1'b0;
      else m_waited++;
    end else if (req_a || req_b) begin
      m_owner_a = (req_a && req_b) ? !m_prev_a : req_a;
      m_prev_a  = m_owner_a;
      m_open    = 1'b1;
      m_waited  = 0;
      grant_log.push_back(m_owner_a);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; req_a = 1'b0; we_a = 1'b0; req_b = 1'b0; we_b = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    m_open = 1'b0; m_owner_a = 1'b0; m_prev_a = 1'b0; m_waited = 0;

    // Reset then idle: the DUT has no defined state before the first edge.
    @(posedge clk);
    @(negedge clk);
    tick();
    reset = 1'b1;
    #1;
    chk("rst_sel",     {31'd0, sel},     32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_busy",    {31'd0, busy},    32'd0);
    tick();
    mem_ack = 1'b1;
    #1;
    chk("idle_ack_a", {31'd0, ack_a}, 32'd0);
    chk("idle_ack_b", {31'd0, ack_b}, 32'd0);
    tick();
    mem_ack = 1'b0;
    tick();

    // Single A read acked in cycle 3.
    req_a = 1'b1; we_a = 1'b0;
    tick();
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      end
      #1;
      chk("rd_sel",     {31'd0, sel},     32'd1);
      chk("rd_mem_req", {31'd0, mem_req}, 32'd1);
      tick();
    end
    mem_ack = 1'b0; req_a = 1'b0;
    #1;
    chk("rd_busy_after", {31'd0, busy}, 32'd0);
    tick();
    // ack cycle re-checked explicitly with a fresh transfer
    req_a = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    chk("rd_ack_a",   {31'd0, ack_a}, 32'd1);
    chk("rd_rdata_a", rdata_a,        32'h1234_5678);
    tick();
    mem_ack = 1'b0; req_a = 1'b0;
    tick();

    // Contention from a fresh reset: expect A,B,A,B and a 2-high/1-low mem_req.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    grant_log.delete();
    req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      mem_ack = ((i % 3) == 2);
      #1;
      chk("cont_mem_req", {31'd0, mem_req}, {31'd0, (i % 3) != 0});
      if ((i % 3) == 1) begin
        chk("cont_order", {31'd0, sel}, {31'd0, ((i / 3) % 2) == 0});
      end
      tick();
    end
    mem_ack = 1'b0; req_a = 1'b0; req_b = 1'b0;
    chk("cont_grants", grant_log.size(), 32'd4);

    // Timeout on B with we_b=1.
    req_b = 1'b1; we_b = 1'b1;
    tick();
    for (int c = 1; c <= TMO; c++) begin
      #1;
      chk("to_mem_we", {31'd0, mem_we}, 32'd1);
      chk("to_sel",    {31'd0, sel},    32'd0);
      chk("to_ack_b",  {31'd0, ack_b},  32'd0);
      chk("to_err_b",  {31'd0, err_b},  {31'd0, c == TMO});
      tick();
    end
    req_b = 1'b0; we_b = 1'b0;
    tick();
    // Tie after B's timeout goes to A; then collide ack with the timeout.
    req_a = 1'b1; req_b = 1'b1;
    tick();
    req_b = 1'b0;
    for (int c = 1; c <= TMO; c++) begin
      mem_ack = (c == TMO);
      #1;
      chk("post_to_sel", {31'd0, sel}, 32'd1);
      if (c == TMO) begin
        chk("coll_ack_a", {31'd0, ack_a}, 32'd1);
        chk("coll_err_a", {31'd0, err_a}, 32'd0);
      end
      tick();
    end
    mem_ack = 1'b0; req_a = 1'b0;
    tick();

    // Reset mid-transfer while A owns the port (last is A at this point).
    req_a = 1'b1;
    tick();
    reset = 1'b0; req_a = 1'b0; mem_ack = 1'b1;
    #1;
    chk("mid_rst_ack_a", {31'd0, ack_a}, 32'd0);
    chk("mid_rst_err_a", {31'd0, err_a}, 32'd0);
    tick();
    reset = 1'b1; mem_ack = 1'b0;
    #1;
    chk("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
    req_a = 1'b1; req_b = 1'b1;
    tick();
    req_b = 1'b0;
    #1;
    chk("mid_rst_tie_a", {31'd0, sel}, 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; req_a = 1'b0;
    tick();

    // Randomized traffic, including protocol violations and stray resets.
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 59) != 0);
      req_a     = ($urandom_range(0, 2) != 0);
      req_b     = ($urandom_range(0, 2) != 0);
      we_a      = $urandom_range(0, 1) == 1;
      we_b      = $urandom_range(0, 1) == 1;
      mem_ack   = ($urandom_range(0, 4) == 0);
      mem_rdata = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 32-bit memory port between two requesters, A and B.
- A is the instruction-side requester; B is the data-side requester.
- Round-robin arbitration. Holds the grant until the memory acknowledges or a timeout fires.
- Drives the select of the existing 2:1 32-bit address/write-data muxes in front of the memory (sel=1 picks A, sel=0 picks B). Routes the ack, error and read data back to the winner.

Parameters:
- TIMEOUT, 16: max cycles in XFER waiting for mem_ack; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- req_a  in  1  requester A wants a transfer
- we_a  in  1  A write enable
- req_b  in  1  requester B wants a transfer
- we_b  in  1  B write enable
- sel  out  1  mux select: 1 = A path, 0 = B path
- mem_req  out  1  transfer request to memory
- mem_we  out  1  granted requester's we
- mem_ack  in  1  memory completes transfer (single-cycle pulse)
- mem_rdata  in  32  memory read data
- ack_a  out  1  A transfer done
- ack_b  out  1  B transfer done
- err_a  out  1  A transfer timed out
- err_b  out  1  B transfer timed out
- rdata_a  out  32  read data to A
- rdata_b  out  32  read data to B
- busy  out  1  state == XFER

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE, last=B, cnt=0, grant=B.
  - Outputs: sel=0, mem_req=0, mem_we=0, ack_a/b=0, err_a/b=0, busy=0.
  - rdata_a/b follow mem_rdata combinationally.
  - Reset mid-XFER abandons the transfer with no ack or err to either side.
- States: IDLE, XFER.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that requester.
  - Both requesting: grant the one that is not `last`.
  - On grant, next state is XFER; register grant and set last=grant; cnt=0.
- XFER:
  - Outputs: mem_req=1; sel=(grant==A); mem_we = grant ? we_a : we_b.
  - mem_ack=1: ack_<grant>=1 in the same cycle (combinational AND with grant and state); next state IDLE.
  - mem_ack=0 and TIMEOUT!=0 and cnt==TIMEOUT-1: err_<grant>=1 in the same cycle; next state IDLE.
  - Otherwise cnt increments.
  - Ack and timeout in the same cycle: ack wins and no err is raised.
- Latency: request sampled in IDLE cycle n → mem_req high in cycle n+1 → earliest ack in n+1. State returns to IDLE in the cycle after ack or err, so there is one dead cycle between transfers. Minimum occupancy is 2 cycles per transfer.
- Requester protocol:
  - Hold req, address, wdata and we stable from assertion until ack or err.
  - Drop req at the edge that samples ack or err, so req is low in the following IDLE cycle.
  - Otherwise the arbiter treats it as a new request.
- Protocol violations:
  - req withdrawn during XFER: the arbiter keeps the grant until ack or timeout.
  - mem_ack in IDLE: ignored, no ack output.
- Fairness: with both requesting continuously, grants alternate A,B,A,B. The first tie after reset goes to A.
- rdata_a and rdata_b are both wired to mem_rdata. They are valid only in the ack cycle.

Decomposition:
- Shared package (cpu_defs):
  - state encoding constants ST_IDLE=1'b0, ST_XFER=1'b1.
  - requester IDs REQ_A=1'b1, REQ_B=1'b0; these match the mux select polarity.
- Sub-module rr_pick2: combinational round-robin pick.
  - Inputs: req_a, req_b, last.
  - Outputs: gnt, valid.
- Counter and FSM stay in the top module.
- The address/wdata muxes stay outside the block, driven by sel.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release → sel=0, mem_req=0, busy=0. mem_ack=1 pulsed in IDLE → ack_a=ack_b=0.
- Single A read: req_a=1 at cycle 0; memory acks at cycle 3 with mem_rdata=32'hDEADBEEF → sel=1 and mem_req=1 in cycles 1-3; ack_a=1 and rdata_a=DEADBEEF in cycle 3; busy=0 in cycle 4.
- Contention: req_a=req_b=1 continuously, memory acks 1 cycle after each mem_req rises → grant order A,B,A,B; mem_req high 2 cycles, low 1 cycle, repeating.
- Timeout: TIMEOUT=4, req_b=1 with we_b=1 and no mem_ack → mem_we=1 and sel=0 for 4 cycles; err_b=1 in the 4th; ack_b never asserted; next grant goes to A if both request.
- Ack/timeout collision: mem_ack on the same cycle cnt==TIMEOUT-1 → ack asserted, err=0.
- Reset mid-transfer: reset=0 during XFER → next cycle mem_req=0, no ack or err; the first post-reset tie grants A.
